// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, fetches over a
// req/ack handshake, and applies ID's branch redirect (flush) and the hazard unit's stall.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    typedef enum logic [1:0] {
        S_START,
        S_REQ,
        S_DROP,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] w_addr_next;
    logic [31:0] r_redirect;
    logic [31:0] w_redirect_next;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_instr_next;
    logic [31:0] r_hold_pc4;
    logic [31:0] w_hold_pc4_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic [31:0] r_pc4;
    logic [31:0] w_pc4_next;
    logic        r_valid;
    logic        w_valid_next;

    logic [31:0] w_target;
    logic [31:0] w_addr_plus4;
    logic [31:0] w_reset_pc;

    // Low address bits are masked so every fetch address stays word aligned.
    assign w_target     = branch_target_i & 32'hFFFF_FFFC;
    assign w_reset_pc   = RESET_PC & 32'hFFFF_FFFC;
    assign w_addr_plus4 = r_addr + 32'd4;

    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_redirect_next   = r_redirect;
        w_hold_instr_next = r_hold_instr;
        w_hold_pc4_next   = r_hold_pc4;
        w_instr_next      = r_instr;
        w_pc4_next        = r_pc4;
        w_valid_next      = r_valid;

        case (r_state)
            S_START: begin
                w_state_next = S_REQ;
                w_addr_next  = w_reset_pc;
            end

            S_REQ: begin
                if (branch_taken_i) begin
                    w_instr_next = NOP_INSTR;
                    w_valid_next = 1'b0;
                    if (imem_ack_i) begin
                        w_addr_next = w_target;
                    end else begin
                        w_redirect_next = w_target;
                        w_state_next    = S_DROP;
                    end
                end else if (imem_ack_i) begin
                    w_addr_next = w_addr_plus4;
                    if (stall_i) begin
                        w_hold_instr_next = imem_rdata_i;
                        w_hold_pc4_next   = w_addr_plus4;
                        w_state_next      = S_HOLD;
                    end else begin
                        w_instr_next = imem_rdata_i;
                        w_pc4_next   = w_addr_plus4;
                        w_valid_next = 1'b1;
                    end
                end else if (!stall_i) begin
                    w_instr_next = NOP_INSTR;
                    w_valid_next = 1'b0;
                end
            end

            S_DROP: begin
                // The in-flight request cannot be cancelled; wait for it, then redirect.
                w_instr_next = NOP_INSTR;
                w_valid_next = 1'b0;
                if (branch_taken_i) begin
                    w_redirect_next = w_target;
                end
                if (imem_ack_i) begin
                    w_addr_next  = branch_taken_i ? w_target : r_redirect;
                    w_state_next = S_REQ;
                end
            end

            S_HOLD: begin
                if (branch_taken_i) begin
                    w_addr_next  = w_target;
                    w_instr_next = NOP_INSTR;
                    w_valid_next = 1'b0;
                    w_state_next = S_REQ;
                end else if (!stall_i) begin
                    w_instr_next = r_hold_instr;
                    w_pc4_next   = r_hold_pc4;
                    w_valid_next = 1'b1;
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_START;
            r_addr       <= w_reset_pc;
            r_redirect   <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc4   <= 32'd0;
            r_instr      <= NOP_INSTR;
            r_pc4        <= 32'd0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_redirect   <= w_redirect_next;
            r_hold_instr <= w_hold_instr_next;
            r_hold_pc4   <= w_hold_pc4_next;
            r_instr      <= w_instr_next;
            r_pc4        <= w_pc4_next;
            r_valid      <= w_valid_next;
        end
    end

    assign imem_req_o    = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr_o   = r_addr;
    assign if_id_instr_o = r_instr;
    assign if_id_pc4_o   = r_pc4;
    assign if_id_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, slow memory, stall/hold, branch flush,
// drop of an in-flight fetch, reset mid-operation and PC wrap.
module tb_if_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_id_instr_o  (if_id_instr_o),
        .if_id_pc4_o    (if_id_pc4_o),
        .if_id_valid_o  (if_id_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and log the resulting state (outputs sampled 1ns after the edge).
    task automatic tick();
        @(posedge clk);
        #1;
        n_cyc++;
        $display("cyc=%0d req=%b addr=%h valid=%b instr=%h pc4=%h", n_cyc, imem_req_o,
                 imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'd0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Zero-wait memory for n cycles; leaves ack low afterwards.
    task automatic fetch_n(input int n);
        imem_ack_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            imem_rdata_i = imem_addr_o ^ K;
            tick();
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr_o); end
        n_checks++; if (if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=00000000", if_id_instr_o); end
        n_checks++; if (if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=00000000", if_id_pc4_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", if_id_valid_o); end
        tick();
        n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL start_req got=%b exp=1", imem_req_o); end
        n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL start_addr got=%h exp=00000000", imem_addr_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL start_valid got=%b exp=0", if_id_valid_o); end
    endtask

    task automatic test_stream();
        logic [31:0] e_pc4;
        do_reset();
        tick();
        imem_ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e_pc4 = 32'(4 * (i + 1));
            imem_rdata_i = imem_addr_o ^ K;
            tick();
            n_checks++; if (if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, if_id_valid_o); end
            n_checks++; if (if_id_pc4_o !== e_pc4) begin n_fail++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", i, if_id_pc4_o, e_pc4); end
            n_checks++; if (if_id_instr_o !== ((e_pc4 - 32'd4) ^ K)) begin n_fail++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, if_id_instr_o, (e_pc4 - 32'd4) ^ K); end
            n_checks++; if (imem_addr_o !== e_pc4) begin n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr_o, e_pc4); end
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_slow_ack();
        logic [31:0] e_addr;
        do_reset();
        tick();
        for (int w = 0; w < 3; w++) begin
            e_addr = 32'(4 * w);
            imem_ack_i = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick();
                n_checks++; if (imem_addr_o !== e_addr || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL slow_wait_addr[%0d] got=%h/%b exp=%h/1", w, imem_addr_o, imem_req_o, e_addr); end
                n_checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL slow_bubble[%0d] got=%b/%h exp=0/00000000", w, if_id_valid_o, if_id_instr_o); end
                n_checks++; if (if_id_pc4_o !== e_addr) begin n_fail++; $display("FAIL slow_bubble_pc4[%0d] got=%h exp=%h", w, if_id_pc4_o, e_addr); end
            end
            imem_ack_i   = 1'b1;
            imem_rdata_i = imem_addr_o ^ K;
            tick();
            n_checks++; if (if_id_valid_o !== 1'b1 || if_id_pc4_o !== e_addr + 32'd4) begin n_fail++; $display("FAIL slow_fetch[%0d] got=%b/%h exp=1/%h", w, if_id_valid_o, if_id_pc4_o, e_addr + 32'd4); end
            n_checks++; if (if_id_instr_o !== (e_addr ^ K)) begin n_fail++; $display("FAIL slow_instr[%0d] got=%h exp=%h", w, if_id_instr_o, e_addr ^ K); end
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        fetch_n(4);
        stall_i      = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h10 ^ K;
        tick();
        imem_ack_i   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got=%b exp=0", c, imem_req_o); end
            n_checks++; if (if_id_pc4_o !== 32'h10 || if_id_instr_o !== (32'hC ^ K) || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_frozen[%0d] got=%h/%h/%b exp=00000010/%h/1", c, if_id_pc4_o, if_id_instr_o, if_id_valid_o, 32'hC ^ K); end
            n_checks++; if (imem_addr_o !== 32'h14) begin n_fail++; $display("FAIL hold_addr[%0d] got=%h exp=00000014", c, imem_addr_o); end
        end
        stall_i = 1'b0;
        tick();
        n_checks++; if (if_id_pc4_o !== 32'h14 || if_id_instr_o !== (32'h10 ^ K) || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL release_ifid got=%h/%h/%b exp=00000014/%h/1", if_id_pc4_o, if_id_instr_o, if_id_valid_o, 32'h10 ^ K); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin n_fail++; $display("FAIL release_req got=%b/%h exp=1/00000014", imem_req_o, imem_addr_o); end
        fetch_n(1);
        n_checks++; if (if_id_pc4_o !== 32'h18 || if_id_instr_o !== (32'h14 ^ K)) begin n_fail++; $display("FAIL after_release got=%h/%h exp=00000018/%h", if_id_pc4_o, if_id_instr_o, 32'h14 ^ K); end
        // Branch while held in the stall buffer: flush wins, buffered word is discarded.
        stall_i      = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h18 ^ K;
        tick();
        imem_ack_i      = 1'b0;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h40;
        tick();
        branch_taken_i = 1'b0;
        stall_i        = 1'b0;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin n_fail++; $display("FAIL hold_branch_req got=%b/%h exp=1/00000040", imem_req_o, imem_addr_o); end
        n_checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL hold_branch_bubble got=%b/%h exp=0/00000000", if_id_valid_o, if_id_instr_o); end
        fetch_n(1);
        n_checks++; if (if_id_pc4_o !== 32'h44 || if_id_instr_o !== (32'h40 ^ K)) begin n_fail++; $display("FAIL hold_branch_next got=%h/%h exp=00000044/%h", if_id_pc4_o, if_id_instr_o, 32'h40 ^ K); end
    endtask

    task automatic test_branch_ack();
        do_reset();
        tick();
        fetch_n(6);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0203;
        imem_ack_i      = 1'b1;
        imem_rdata_i    = 32'hDEAD_BEEF;
        tick();
        branch_taken_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL br_ack_addr got=%h/%b exp=00000200/1", imem_addr_o, imem_req_o); end
        n_checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL br_ack_bubble got=%b/%h exp=0/00000000", if_id_valid_o, if_id_instr_o); end
        imem_rdata_i = 32'h200 ^ K;
        tick();
        imem_ack_i = 1'b0;
        n_checks++; if (if_id_valid_o !== 1'b1 || if_id_pc4_o !== 32'h204 || if_id_instr_o !== (32'h200 ^ K)) begin n_fail++; $display("FAIL br_ack_target got=%b/%h/%h exp=1/00000204/%h", if_id_valid_o, if_id_pc4_o, if_id_instr_o, 32'h200 ^ K); end
    endtask

    task automatic test_branch_drop();
        do_reset();
        tick();
        fetch_n(8);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h100;
        tick();
        branch_taken_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'h20 || imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_enter got=%h/%b/%b exp=00000020/1/0", imem_addr_o, imem_req_o, if_id_valid_o); end
        tick();
        n_checks++; if (imem_addr_o !== 32'h20 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_wait got=%h/%b exp=00000020/0", imem_addr_o, if_id_valid_o); end
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hBAD0_0020;
        tick();
        n_checks++; if (imem_addr_o !== 32'h100 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_redirect got=%h/%b exp=00000100/0", imem_addr_o, if_id_valid_o); end
        fetch_n(1);
        n_checks++; if (if_id_pc4_o !== 32'h104 || if_id_instr_o !== (32'h100 ^ K) || if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL drop_target_fetch got=%h/%h/%b exp=00000104/%h/1", if_id_pc4_o, if_id_instr_o, if_id_valid_o, 32'h100 ^ K); end
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h180;
        tick();
        branch_target_i = 32'h300;
        tick();
        branch_taken_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'h104 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop2_hold got=%h/%b exp=00000104/0", imem_addr_o, if_id_valid_o); end
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hBAD0_0104;
        tick();
        imem_ack_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'h300 || imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop2_redirect got=%h/%b/%b exp=00000300/1/0", imem_addr_o, imem_req_o, if_id_valid_o); end
        fetch_n(1);
        n_checks++; if (if_id_pc4_o !== 32'h304 || if_id_instr_o !== (32'h300 ^ K)) begin n_fail++; $display("FAIL drop2_fetch got=%h/%h exp=00000304/%h", if_id_pc4_o, if_id_instr_o, 32'h300 ^ K); end
    endtask

    task automatic test_reset_mid_and_wrap();
        do_reset();
        tick();
        fetch_n(3);
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h80;
        tick();
        branch_taken_i = 1'b0;
        rst_n          = 1'b0;
        tick();
        n_checks++; if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_addr_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL rst_in_drop got=%b/%b/%h/%h/%h exp=0/0/00000000/00000000/00000000", imem_req_o, if_id_valid_o, if_id_instr_o, imem_addr_o, if_id_pc4_o); end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL restart_req got=%b/%h exp=1/00000000", imem_req_o, imem_addr_o); end
        fetch_n(2);
        stall_i      = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h8 ^ K;
        tick();
        imem_ack_i = 1'b0;
        rst_n      = 1'b0;
        tick();
        stall_i = 1'b0;
        n_checks++; if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_in_hold got=%b/%b/%h/%h exp=0/0/00000000/00000000", imem_req_o, if_id_valid_o, if_id_instr_o, imem_addr_o); end
        rst_n = 1'b1;
        tick();
        tick();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        imem_ack_i      = 1'b1;
        imem_rdata_i    = 32'h1234_5678;
        tick();
        branch_taken_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_addr_o); end
        imem_rdata_i = 32'hFFFF_FFFC ^ K;
        tick();
        imem_ack_i = 1'b0;
        n_checks++; if (if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b1 || if_id_instr_o !== (32'hFFFF_FFFC ^ K)) begin n_fail++; $display("FAIL wrap_pc4 got=%h/%b/%h exp=00000000/1/%h", if_id_pc4_o, if_id_valid_o, if_id_instr_o, 32'hFFFF_FFFC ^ K); end
        n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr_o); end
    endtask

    initial begin
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'd0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'd0;
        test_reset();
        test_stream();
        test_slow_ack();
        test_stall();
        test_branch_ack();
        test_branch_drop();
        test_reset_mid_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
